// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory responder.
//   state_t    : responder FSM encoding (IDLE, BUSY, DONE)
//   IMEM_NOP   : word returned on a faulted fetch
//   imem_idx_w : word-index width for a given storage depth
// Optional feature macro used by the responder files: IMEM_PREFETCH_EN
// -----------------------------------------------------------------------------
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

  // Word-index width; a one-word store still needs a 1-bit index.
  function automatic int imem_idx_w(input int depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// -----------------------------------------------------------------------------
// imem_responder_if
// Fetch request/response bundle plus the preload write port.
//   master : IF stage / preload agent (drives req, pc, flush, wr_*)
//   slave  : imem_responder (drives ready, instr_valid, instr, fault)
// Signals:
//   req, pc[31:0], flush           fetch request, byte address, redirect
//   ready, instr_valid, instr, fault  accept-ready and one-cycle response
//   wr_en, wr_addr[31:0], wr_data  preload word write
// -----------------------------------------------------------------------------
interface imem_responder_if;
  logic        req;
  logic [31:0] pc;
  logic        flush;
  logic        ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic        fault;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output req, pc, flush, wr_en, wr_addr, wr_data,
    input  ready, instr_valid, instr, fault
  );

  modport slave (
    input  req, pc, flush, wr_en, wr_addr, wr_data,
    output ready, instr_valid, instr, fault
  );
endinterface

// File: rtl/imem_array.sv
// -----------------------------------------------------------------------------
// imem_array
// DEPTH_WORDS x 32 program storage. One synchronous write port, one registered
// read port (read-before-write on an address collision). Contents are never
// reset. With IMEM_PREFETCH_EN defined, a second registered read port feeds the
// prefetch buffer.
// Ports:
//   i_clock                          clock
//   i_wr_en, i_wr_idx, i_wr_data     word write
//   i_rd_en, i_rd_idx, o_rd_data     fetch read, data valid the cycle after
//   i_rd2_en, i_rd2_idx, o_rd2_data  prefetch read (IMEM_PREFETCH_EN only)
// -----------------------------------------------------------------------------
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                              i_clock,
  input  logic                              i_wr_en,
  input  logic [imem_idx_w(DEPTH_WORDS)-1:0] i_wr_idx,
  input  logic [31:0]                       i_wr_data,
  input  logic                              i_rd_en,
  input  logic [imem_idx_w(DEPTH_WORDS)-1:0] i_rd_idx,
`ifdef IMEM_PREFETCH_EN
  input  logic                              i_rd2_en,
  input  logic [imem_idx_w(DEPTH_WORDS)-1:0] i_rd2_idx,
  output logic [31:0]                       o_rd2_data,
`endif
  output logic [31:0]                       o_rd_data
);
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rd_data;

  always_ff @(posedge i_clock) begin
    if (i_wr_en) r_mem[i_wr_idx] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_idx];
  end
  assign o_rd_data = r_rd_data;

`ifdef IMEM_PREFETCH_EN
  logic [31:0] r_rd2_data;
  always_ff @(posedge i_clock) begin
    if (i_rd2_en) r_rd2_data <= r_mem[i_rd2_idx];
  end
  assign o_rd2_data = r_rd2_data;
`endif
endmodule

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
// Instruction-memory responder for the fetch stage. Accepts one fetch per
// req&&ready handshake, returns the word LATENCY cycles later as a one-cycle
// instr_valid pulse, flags misaligned / out-of-range fetches, and drops an
// outstanding fetch on flush. instr/fault hold their last pulsed values.
// Optional IMEM_PREFETCH_EN: one-entry sequential prefetch buffer.
// Parameters: DEPTH_WORDS (power of two), LATENCY (1..15)
// Ports:
//   i_clock   clock
//   i_resetn  synchronous active-low reset
//   bus       imem_responder_if.slave (fetch + preload signals)
// -----------------------------------------------------------------------------
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            i_clock,
  input  logic            i_resetn,
  imem_responder_if.slave bus
);
  localparam int         AW     = imem_idx_w(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_count, w_count_nxt;
  logic          r_pend_fault, r_src_pf, r_hold_fault;
  logic [31:0]   r_hold_instr;
  logic          w_ready, w_accept, w_valid, w_fault, w_wr_en;
  logic [AW-1:0] w_idx, w_wr_idx;
  logic [31:0]   w_wr_word, w_rd_data, w_rd2_data, w_resp;
  logic          w_pf_hit, w_pf_match;
  logic [3:0]    w_pf_cnt;

  assign w_idx     = bus.pc[AW+1:2];
  assign w_fault   = (bus.pc[1:0] != 2'b00) || ((bus.pc >> (AW + 2)) != 32'd0);
  // Out-of-range preload writes are dropped rather than aliased.
  assign w_wr_word = bus.wr_addr >> 2;
  assign w_wr_idx  = w_wr_word[AW-1:0];
  assign w_wr_en   = bus.wr_en && ((w_wr_word >> AW) == 32'd0);

  // Ready is forced low during reset so nothing is accepted before release.
  assign w_ready  = i_resetn && ((r_state == ST_IDLE) || (r_state == ST_DONE) || bus.flush);
  assign w_accept = bus.req && w_ready;
  assign w_valid  = i_resetn && (r_state == ST_DONE) && !bus.flush;

`ifdef IMEM_PREFETCH_EN
  logic          r_pf_valid, r_pf_busy;
  logic [3:0]    r_pf_cnt;
  logic [AW-1:0] r_pf_tag, r_cur_idx, w_pf_next_idx;
  logic          w_pf_tag_ok, w_pf_start;

  assign w_pf_next_idx = r_cur_idx + AW'(1);
  assign w_pf_tag_ok   = !bus.flush && !w_fault && (w_idx == r_pf_tag);
  assign w_pf_hit      = r_pf_valid && w_pf_tag_ok;
  assign w_pf_match    = r_pf_busy && w_pf_tag_ok;
  assign w_pf_cnt      = r_pf_cnt;
  // Background fetch of A+4 after a clean response that leaves us idle. A
  // write landing on A+4 at the start edge would make the read stale, so skip.
  assign w_pf_start = w_valid && !r_pend_fault && !w_accept && (r_cur_idx != '1) &&
                      !(w_wr_en && (w_wr_idx == w_pf_next_idx));

  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_pf_valid <= 1'b0;
      r_pf_busy  <= 1'b0;
      r_pf_cnt   <= 4'd0;
      r_pf_tag   <= '0;
      r_cur_idx  <= '0;
    end else begin
      if (w_accept) r_cur_idx <= w_idx;
      // Same countdown as BUSY so a matching request finishes in step.
      if (r_pf_busy) begin
        if (r_pf_cnt <= 4'd1) begin
          r_pf_busy  <= 1'b0;
          r_pf_valid <= 1'b1;
        end else begin
          r_pf_cnt <= r_pf_cnt - 4'd1;
        end
      end
      if (w_accept && !w_pf_hit && !w_pf_match && r_pf_busy) begin
        r_pf_busy  <= 1'b0;
        r_pf_valid <= 1'b0;
      end
      if (w_pf_start) begin
        r_pf_tag   <= w_pf_next_idx;
        r_pf_cnt   <= LAT_M1;
        r_pf_busy  <= (LATENCY != 1);
        r_pf_valid <= (LATENCY == 1);
      end
      if (bus.flush || (w_wr_en && (w_wr_idx == r_pf_tag))) begin
        r_pf_valid <= 1'b0;
        r_pf_busy  <= 1'b0;
      end
    end
  end
`else
  assign w_pf_hit   = 1'b0;
  assign w_pf_match = 1'b0;
  assign w_pf_cnt   = 4'd0;
  assign w_rd2_data = IMEM_NOP;
`endif

  imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .i_clock   (i_clock),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (bus.wr_data),
    .i_rd_en   (w_accept),
    .i_rd_idx  (w_idx),
`ifdef IMEM_PREFETCH_EN
    .i_rd2_en  (w_pf_start),
    .i_rd2_idx (w_pf_next_idx),
    .o_rd2_data(w_rd2_data),
`endif
    .o_rd_data (w_rd_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      ST_BUSY: begin
        if (r_count <= 4'd1) begin
          w_state_nxt = ST_DONE;
          w_count_nxt = 4'd0;
        end else begin
          w_count_nxt = r_count - 4'd1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = r_state;
    endcase
    // A redirect drops whatever is outstanding; a same-cycle req restarts below.
    if (bus.flush) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = 4'd0;
    end
    if (w_accept) begin
      if (w_pf_hit || (w_pf_match && (w_pf_cnt <= 4'd1)) || (LATENCY == 1)) begin
        w_state_nxt = ST_DONE;
        w_count_nxt = 4'd0;
      end else if (w_pf_match) begin
        w_state_nxt = ST_BUSY;
        w_count_nxt = w_pf_cnt - 4'd1;
      end else begin
        w_state_nxt = ST_BUSY;
        w_count_nxt = LAT_M1;
      end
    end
  end

  assign w_resp = r_pend_fault ? IMEM_NOP : (r_src_pf ? w_rd2_data : w_rd_data);

  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_state      <= ST_IDLE;
      r_count      <= 4'd0;
      r_pend_fault <= 1'b0;
      r_src_pf     <= 1'b0;
      r_hold_instr <= IMEM_NOP;
      r_hold_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_accept) begin
        r_pend_fault <= w_fault;
        r_src_pf     <= w_pf_hit || w_pf_match;
      end
      // Capture the pulsed response so outputs hold it until the next pulse.
      if (w_valid) begin
        r_hold_instr <= w_resp;
        r_hold_fault <= r_pend_fault;
      end
    end
  end

  assign bus.ready       = w_ready;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = w_valid ? w_resp : r_hold_instr;
  assign bus.fault       = w_valid ? r_pend_fault : r_hold_fault;
endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
// Self-checking bench for imem_responder (DEPTH_WORDS=1024, LATENCY=2).
// Per-cycle vector table for the main fetch/fault/flush/collision behaviour,
// hand-written sequences for reset mid-fetch and (with IMEM_PREFETCH_EN) the
// prefetch buffer.
// -----------------------------------------------------------------------------
module tb_imem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  imem_responder_if bus ();

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .i_clock (clk),
    .i_resetn(resetn),
    .bus     (bus)
  );

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        flush;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        rdy;
    logic        val;
    logic [31:0] ins;
    logic        flt;
  } vec_t;

  vec_t tbl[$];
  int   n_errors = 0;
  int   n_checks = 0;

  function automatic vec_t mk(input logic req, input logic [31:0] pc, input logic flush,
                              input logic we, input logic [31:0] wa, input logic [31:0] wd,
                              input logic rdy, input logic val, input logic [31:0] ins,
                              input logic flt);
    vec_t v;
    v.req = req; v.pc = pc; v.flush = flush;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.rdy = rdy; v.val = val; v.ins = ins; v.flt = flt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic drive(input logic req, input logic [31:0] pc, input logic flush,
                       input logic we, input logic [31:0] wa, input logic [31:0] wd);
    @(posedge clk);
    #1;
    bus.req = req; bus.pc = pc; bus.flush = flush;
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
  endtask

  // Outputs are sampled mid-cycle, well away from either clock edge.
  task automatic check_out(input string tag, input logic rdy, input logic val,
                           input logic [31:0] ins, input logic flt);
    #3;
    $display("%s: ready=%0b valid=%0b instr=%h fault=%0b", tag,
             bus.ready, bus.instr_valid, bus.instr, bus.fault);
    chk({tag, ".ready"}, {31'd0, bus.ready}, {31'd0, rdy});
    chk({tag, ".valid"}, {31'd0, bus.instr_valid}, {31'd0, val});
    chk({tag, ".instr"}, bus.instr, ins);
    chk({tag, ".fault"}, {31'd0, bus.fault}, {31'd0, flt});
  endtask

  task automatic idle_chk(input string tag, input logic rdy, input logic val,
                          input logic [31:0] ins, input logic flt);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_out(tag, rdy, val, ins, flt);
  endtask

  initial begin
    bus.req = 1'b0; bus.pc = 32'd0; bus.flush = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = 32'd0; bus.wr_data = 32'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check_out("release", 1'b1, 1'b0, 32'h0, 1'b0);

    // Preload.
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000, 32'h2008_0005);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0004, 32'h2009_000A);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0008, 32'hAAAA_0001);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0040, 32'h1111_2222);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0FFC, 32'hCAFE_F00D);

    //                 req  pc            fl  we  waddr  wdata          rdy val instr          flt
    tbl.push_back(mk(1, 32'h0000_0000, 0, 0, 32'h0, 32'h0,          1, 0, 32'h0000_0000, 0)); // c0 accept pc0
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0, 32'h0,          0, 0, 32'h0000_0000, 0)); // c1 busy
    tbl.push_back(mk(1, 32'h0000_0004, 0, 0, 32'h0, 32'h0,          1, 1, 32'h2008_0005, 0)); // c2 done + accept pc4
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0, 32'h0,          0, 0, 32'h2008_0005, 0)); // c3 hold
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0, 32'h0,          1, 1, 32'h2009_000A, 0)); // c4 done pc4
    tbl.push_back(mk(1, 32'h0000_0002, 0, 0, 32'h0, 32'h0,          1, 0, 32'h2009_000A, 0)); // c5 misaligned
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0, 32'h0,          0, 0, 32'h2009_000A, 0)); // c6
    tbl.push_back(mk(1, 32'h0000_1000, 0, 0, 32'h0, 32'h0,          1, 1, 32'h0000_0000, 1)); // c7 fault + accept OOR
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0, 32'h0,          0, 0, 32'h0000_0000, 1)); // c8
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0, 32'h0,          1, 1, 32'h0000_0000, 1)); // c9 OOR fault
    tbl.push_back(mk(1, 32'h0000_0000, 0, 0, 32'h0, 32'h0,          1, 0, 32'h0000_0000, 1)); // c10 accept pc0
    tbl.push_back(mk(1, 32'h0000_0040, 1, 0, 32'h0, 32'h0,          1, 0, 32'h0000_0000, 1)); // c11 flush + req 0x40
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0, 32'h0,          0, 0, 32'h0000_0000, 1)); // c12 no pc0 reply
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0, 32'h0,          1, 1, 32'h1111_2222, 0)); // c13 reply 0x40
    tbl.push_back(mk(0, 32'h0,         1, 0, 32'h0, 32'h0,          1, 0, 32'h1111_2222, 0)); // c14 idle flush
    tbl.push_back(mk(1, 32'h0000_0000, 0, 0, 32'h0, 32'h0,          1, 0, 32'h1111_2222, 0)); // c15 accept pc0
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0, 32'h0,          0, 0, 32'h1111_2222, 0)); // c16
    tbl.push_back(mk(0, 32'h0,         1, 0, 32'h0, 32'h0,          1, 0, 32'h1111_2222, 0)); // c17 flush in DONE
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0, 32'h0,          1, 0, 32'h1111_2222, 0)); // c18
    tbl.push_back(mk(1, 32'h0000_0FFC, 0, 0, 32'h0, 32'h0,          1, 0, 32'h1111_2222, 0)); // c19 last word
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0, 32'h0,          0, 0, 32'h1111_2222, 0)); // c20
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0, 32'h0,          1, 1, 32'hCAFE_F00D, 0)); // c21
    tbl.push_back(mk(1, 32'h0000_0008, 0, 1, 32'h8, 32'hBBBB_0002,  1, 0, 32'hCAFE_F00D, 0)); // c22 accept + write same word
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0, 32'h0,          0, 0, 32'hCAFE_F00D, 0)); // c23
    tbl.push_back(mk(1, 32'h0000_0008, 0, 0, 32'h0, 32'h0,          1, 1, 32'hAAAA_0001, 0)); // c24 old data
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0, 32'h0,          0, 0, 32'hAAAA_0001, 0)); // c25
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0, 32'h0,          1, 1, 32'hBBBB_0002, 0)); // c26 new data
    tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0, 32'h0,          1, 0, 32'hBBBB_0002, 0)); // c27

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].req, tbl[i].pc, tbl[i].flush, tbl[i].wr_en, tbl[i].wr_addr, tbl[i].wr_data);
      check_out($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].val, tbl[i].ins, tbl[i].flt);
    end

    // Reset in the middle of a fetch: no response, ready low, storage kept.
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_out("rst_acc", 1'b1, 1'b0, 32'hBBBB_0002, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    resetn = 1'b0;
    check_out("rst_mid", 1'b0, 1'b0, 32'hBBBB_0002, 1'b0);
    idle_chk("rst_hold", 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    resetn = 1'b1;
    check_out("rst_rel", 1'b1, 1'b0, 32'h0, 1'b0);
    idle_chk("rst_idle1", 1'b1, 1'b0, 32'h0, 1'b0);
    idle_chk("rst_idle2", 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_out("keep_acc", 1'b1, 1'b0, 32'h0, 1'b0);
    idle_chk("keep_busy", 1'b0, 1'b0, 32'h0, 1'b0);
    idle_chk("keep_done", 1'b1, 1'b1, 32'h2008_0005, 1'b0);
    idle_chk("keep_idle", 1'b1, 1'b0, 32'h2008_0005, 1'b0);

`ifdef IMEM_PREFETCH_EN
    // Prefetch hit: pc4 returns one cycle after accept.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'd0, 32'd0);
    check_out("pf_flush", 1'b1, 1'b0, 32'h2008_0005, 1'b0);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_out("pf_acc0", 1'b1, 1'b0, 32'h2008_0005, 1'b0);
    idle_chk("pf_busy0", 1'b0, 1'b0, 32'h2008_0005, 1'b0);
    idle_chk("pf_done0", 1'b1, 1'b1, 32'h2008_0005, 1'b0);
    for (int i = 0; i < 3; i++) idle_chk($sformatf("pf_idle%0d", i), 1'b1, 1'b0, 32'h2008_0005, 1'b0);
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0);
    check_out("pf_acc4", 1'b1, 1'b0, 32'h2008_0005, 1'b0);
    idle_chk("pf_hit", 1'b1, 1'b1, 32'h2009_000A, 1'b0);
    idle_chk("pf_after", 1'b1, 1'b0, 32'h2009_000A, 1'b0);

    // Write to the buffered word invalidates it: full latency, new data.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'd0, 32'd0);
    check_out("pfw_flush", 1'b1, 1'b0, 32'h2009_000A, 1'b0);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_out("pfw_acc0", 1'b1, 1'b0, 32'h2009_000A, 1'b0);
    idle_chk("pfw_busy0", 1'b0, 1'b0, 32'h2009_000A, 1'b0);
    idle_chk("pfw_done0", 1'b1, 1'b1, 32'h2008_0005, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 32'hDEAD_BEEF);
    check_out("pfw_write", 1'b1, 1'b0, 32'h2008_0005, 1'b0);
    idle_chk("pfw_idle1", 1'b1, 1'b0, 32'h2008_0005, 1'b0);
    idle_chk("pfw_idle2", 1'b1, 1'b0, 32'h2008_0005, 1'b0);
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0);
    check_out("pfw_acc4", 1'b1, 1'b0, 32'h2008_0005, 1'b0);
    idle_chk("pfw_busy4", 1'b0, 1'b0, 32'h2008_0005, 1'b0);
    idle_chk("pfw_done4", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
